reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
Upstream request stage that drives the register-bus DUT port (wr, en, addr, wdata, rdata). It accepts read/write commands over a valid/ready channel and buffers them in a small command FIFO. It sequences them onto the register bus one access at a time and returns read data over a valid/ready response channel. It sits between the stimulus/driver side of the top level and the DUT wrapper.

Parameters:
ADDR_W, 8, register bus address width
DATA_W, 16, register bus data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
RD_LAT, 1, cycles from read-enable cycle to rdata valid (1..4)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  command address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  read response valid
rsp_ready  in  1  consumer accepts response
rsp_addr  out  ADDR_W  address of the returned read
rsp_rdata  out  DATA_W  read data
wr  out  1  bus write strobe qualifier
en  out  1  bus access enable, one cycle per access
addr  out  ADDR_W  bus address
wdata  out  DATA_W  bus write data
rdata  in  DATA_W  bus read data
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: synchronous, active-high, checked every clk edge. All outputs go to 0 except cmd_ready, which goes to 1. FIFO is emptied. FSM goes to IDLE. Reset mid-read drops the in-flight read and any pending response without emitting it.
- Command accept: a command is pushed when cmd_valid && cmd_ready. cmd_ready = !full, registered view of occupancy. A push into a full FIFO cannot occur.
- FIFO: FIFO_DEPTH entries of {wr, addr, wdata}, with log2(FIFO_DEPTH)+1-bit pointers and the MSB distinguishing full from empty. Pointers wrap modulo 2*FIFO_DEPTH. Simultaneous push and pop when full or empty is legal; occupancy is unchanged when both happen.
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
  - IDLE -> ISSUE when the FIFO is non-empty. Pop and register the head into the bus regs.
  - ISSUE: en=1 for exactly one cycle, with wr/addr/wdata from the popped entry.
    - Write: if the FIFO is non-empty, pop the next entry and stay in ISSUE, giving back-to-back writes at 1 per cycle. Otherwise go to IDLE.
    - Read: go to WAIT_RD and load the latency counter with RD_LAT-1.
  - WAIT_RD: en=0. Count down. When the count reaches 0 (RD_LAT cycles after the en cycle), capture rdata into rsp_rdata and go to RESP.
  - RESP: rsp_valid=1, holding rsp_addr/rsp_rdata stable until rsp_ready. On rsp_valid && rsp_ready, go to ISSUE (with a pop) if the FIFO is non-empty, else IDLE.
- Only one access is in flight at a time. Accesses are strictly in command order, and a read blocks later writes until its response is accepted.
- Outside ISSUE: en=0 and wr=0. addr/wdata hold their last values.
- Latency:
  - Write: accepted at edge N gives en=1 during cycle N+2 from an empty, idle block (one FIFO cycle plus one register stage).
  - Read: rsp_valid asserts RD_LAT+1 cycles after its en cycle.

Optional Feature:
- Macro: REG_BUS_MST_STATS_EN.
- Defined: adds outputs rd_cnt[15:0] and wr_cnt[15:0].
  - Each increments on an ISSUE cycle of the matching type.
  - Both saturate at 16'hFFFF.
  - Both clear on rst.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package reg_bus_pkg holds:
  - ADDR_W/DATA_W defaults;
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} mst_state_t;
  - typedef struct packed {logic wr; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata;} reg_cmd_t.
- One sub-module: reg_cmd_fifo, the synchronous FIFO with push/pop/full/empty.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, cmd_ready=1, busy=0. No en pulse for 10 cycles.
- Single write addr=8'h04, wdata=16'hA5A5 -> exactly one en=1, wr=1 cycle with those values, 2 cycles after acceptance. No rsp_valid.
- Write 16'h1234 to 8'h10, then read 8'h10 with a bus model returning stored data at RD_LAT=1 -> rsp_valid with rsp_addr=8'h10, rsp_rdata=16'h1234.
- Fill: 5 writes offered with rsp path idle and bus stalled behind a pending read with rsp_ready=0 -> cmd_ready drops after 4 entries. After rsp_ready=1, all entries drain in order. Back-to-back writes give en=1 on consecutive cycles.
- Response backpressure: read response held with rsp_ready=0 for 6 cycles -> rsp_valid, rsp_addr and rsp_rdata stable, and no new en until the handshake.
- Reset mid-read: rst asserted during WAIT_RD -> no rsp_valid afterwards, FIFO empty, FSM in IDLE. With REG_BUS_MST_STATS_EN defined, rd_cnt=0.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared defaults, FSM state type and command layout for the register-bus master.
package reg_bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} mst_state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } reg_cmd_t;

  // Flattened command width {wr, addr, wdata} for non-default bus widths.
  function automatic int cmd_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// Synchronous command FIFO; extra pointer MSB separates full from empty.
module reg_cmd_fifo
  import reg_bus_pkg::*;
#(
  parameter int W     = cmd_width(DEF_ADDR_W, DEF_DATA_W),
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so push-while-full is allowed then.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus master: buffers commands and issues them one access at a time.
// Define REG_BUS_MST_STATS_EN to add saturating rd_cnt/wr_cnt access counters.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy
`ifdef REG_BUS_MST_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mst_state_t        r_state;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CMD_W-1:0]  w_head;
  logic              w_head_wr;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;

  assign w_push = cmd_valid && !w_full;
  // Head is consumed whenever the FSM is ready to start the next access.
  assign w_pop  = !w_empty && ((r_state == IDLE) ||
                               (r_state == ISSUE && r_wr) ||
                               (r_state == RESP && rsp_ready));

  reg_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({cmd_wr, cmd_addr, cmd_wdata}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign {w_head_wr, w_head_addr, w_head_wdata} = w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lat_cnt   <= '0;
      r_rsp_addr  <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_pop) begin
        r_wr    <= w_head_wr;
        r_addr  <= w_head_addr;
        r_wdata <= w_head_wdata;
      end
      unique case (r_state)
        IDLE:    if (w_pop) r_state <= ISSUE;
        ISSUE: begin
          if (!r_wr) begin
            r_state   <= WAIT_RD;
            r_lat_cnt <= LAT_LOAD;
          end else if (!w_pop) begin
            r_state <= IDLE;
          end
        end
        WAIT_RD: begin
          if (r_lat_cnt == '0) begin
            r_rsp_addr  <= r_addr;
            r_rsp_rdata <= rdata;
            r_state     <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - CNT_ONE;
          end
        end
        RESP:    if (rsp_ready) r_state <= w_pop ? ISSUE : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign en        = (r_state == ISSUE);
  assign wr        = r_wr && en;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rsp_valid = (r_state == RESP);
  assign rsp_addr  = r_rsp_addr;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = !w_empty || (r_state != IDLE);

`ifdef REG_BUS_MST_STATS_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (en) begin
      if (r_wr && r_wr_cnt != 16'hFFFF)  r_wr_cnt <= r_wr_cnt + 16'd1;
      if (!r_wr && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master with an RD_LAT=1 register-bus memory model.
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              wr;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              busy;
`ifdef REG_BUS_MST_STATS_EN
  logic [15:0]       rd_cnt;
  logic [15:0]       wr_cnt;
`endif

  always #5 clk = ~clk;

  reg_bus_master #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .wr        (wr),
    .en        (en),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy)
`ifdef REG_BUS_MST_STATS_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
`endif
  );

  // Bus slave: writes land on the en edge, read data appears one cycle later.
  logic [DATA_W-1:0] bus_mem [256];
  always @(posedge clk) begin
    if (en && wr)  bus_mem[addr] <= wdata;
    if (en && !wr) rdata <= bus_mem[addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  reg_cmd_t          exp_bus [$];
  logic [23:0]       exp_rsp [$];
  logic [DATA_W-1:0] sb_mem  [256];
  int                n_wr_exp = 0;
  int                n_rd_exp = 0;

  // Monitor: every en cycle and every response handshake is scored here.
  reg_cmd_t    mon_e;
  logic [23:0] mon_r;
  int          run_len = 0;
  int          max_run = 0;
  int          cyc = 0;
  int          rd_en_cyc = 0;
  logic        prev_rsp_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (en) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        $display("bus %s addr=%h wdata=%h", wr ? "WR" : "RD", addr, wdata);
        if (!wr) rd_en_cyc = cyc;
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_bus.pop_front();
          check("bus_wr", {31'd0, wr}, {31'd0, mon_e.wr});
          check("bus_addr", {24'd0, addr}, {24'd0, mon_e.addr});
          if (mon_e.wr) check("bus_wdata", {16'd0, wdata}, {16'd0, mon_e.wdata});
        end
      end else begin
        run_len = 0;
      end
      if (rsp_valid && !prev_rsp_valid) check("rsp_lat", 32'(cyc - rd_en_cyc), 32'(RD_LAT + 1));
      if (rsp_valid && rsp_ready) begin
        $display("rsp addr=%h rdata=%h", rsp_addr, rsp_rdata);
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_r = exp_rsp.pop_front();
          check("rsp_addr", {24'd0, rsp_addr}, {24'd0, mon_r[23:16]});
          check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, mon_r[15:0]});
        end
      end
    end
    prev_rsp_valid = rsp_valid;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic w, input logic [7:0] a, input logic [15:0] d);
    int       n;
    bit       done;
    reg_cmd_t c;
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_addr  = a;
    cmd_wdata = d;
    done = 1'b0;
    n    = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        done    = 1'b1;
        c.wr    = w;
        c.addr  = a;
        c.wdata = d;
        exp_bus.push_back(c);
        if (w) begin
          sb_mem[a] = d;
          n_wr_exp++;
        end else begin
          exp_rsp.push_back({a, sb_mem[a]});
          n_rd_exp++;
        end
      end
      @(posedge clk);
      #1;
      n++;
      // A long stall means the response path is blocking the FIFO; release it.
      if (n == 8) rsp_ready = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!done) check("cmd_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_bus.size() != 0 || exp_rsp.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(exp_bus.size() + exp_rsp.size()) + {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_wdata", {16'd0, wdata}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_addr", {24'd0, rsp_addr}, 32'd0);
    check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef REG_BUS_MST_STATS_EN
    check("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
    check("rst_wr_cnt", {16'd0, wr_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_en", {31'd0, en}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Single write: en one cycle after the accepting edge, for exactly one cycle.
    send(1'b1, 8'h04, 16'hA5A5);
    check("wr_lat_pre_en", {31'd0, en}, 32'd0);
    @(posedge clk);
    #1;
    check("wr_lat_en", {31'd0, en}, 32'd1);
    check("wr_lat_wr", {31'd0, wr}, 32'd1);
    check("wr_lat_addr", {24'd0, addr}, 32'h04);
    check("wr_lat_wdata", {16'd0, wdata}, 32'hA5A5);
    @(posedge clk);
    #1;
    check("wr_lat_post_en", {31'd0, en}, 32'd0);
    check("wr_lat_post_wr", {31'd0, wr}, 32'd0);
    check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    wait_idle("wr_drain");

    // Write then read back through the bus model.
    send(1'b1, 8'h10, 16'h1234);
    send(1'b0, 8'h10, 16'h0000);
    wait_idle("wr_rd_drain");

    // Fill: a read parked in RESP stalls the bus while four writes fill the FIFO.
    rsp_ready = 1'b0;
    send(1'b1, 8'h20, 16'hBEEF);
    send(1'b0, 8'h20, 16'h0000);
    wait_rsp("fill_rsp");
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h30 + i), 16'(16'hC000 + i));
    @(negedge clk);
    check("fill_ready", {31'd0, cmd_ready}, 32'd0);
    check("fill_busy", {31'd0, busy}, 32'd1);
    check("fill_en", {31'd0, en}, 32'd0);
    @(posedge clk);
    #1;
    max_run   = 0;
    rsp_ready = 1'b1;
    send(1'b1, 8'h34, 16'hC004);
    wait_idle("fill_drain");
    check("b2b_run", {31'd0, max_run >= 4}, 32'd1);

    // Response backpressure: held response stays stable and blocks the next write.
    rsp_ready = 1'b0;
    send(1'b0, 8'h10, 16'h0000);
    send(1'b1, 8'h11, 16'h7777);
    wait_rsp("bp_rsp");
    repeat (6) begin
      @(negedge clk);
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_addr", {24'd0, rsp_addr}, 32'h10);
      check("bp_rdata", {16'd0, rsp_rdata}, 32'h1234);
      check("bp_en", {31'd0, en}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    wait_idle("bp_drain");

    // Reset while the read waits for data: the response must never appear.
    send(1'b0, 8'h04, 16'h0000);
    begin
      int n = 0;
      while (!(en && !wr) && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("mr_rd_en", {31'd0, en && !wr}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rsp.delete();
    n_wr_exp = 0;
    n_rd_exp = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end
    check("mr_bus_q", 32'(exp_bus.size()), 32'd0);
`ifdef REG_BUS_MST_STATS_EN
    check("mr_rd_cnt", {16'd0, rd_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;

    // Mixed traffic over a small, pre-written address window.
    for (int i = 0; i < 8; i++) send(1'b1, 8'(8'h40 + i), 16'($urandom));
    for (int i = 0; i < 30; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      send(1'($urandom_range(0, 1)), 8'(8'h40 + $urandom_range(0, 7)), 16'($urandom));
    end
    rsp_ready = 1'b1;
    wait_idle("rand_drain");
`ifdef REG_BUS_MST_STATS_EN
    check("stat_wr_cnt", {16'd0, wr_cnt}, 32'(n_wr_exp));
    check("stat_rd_cnt", {16'd0, rd_cnt}, 32'(n_rd_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
